// File: rtl/dbus_axi_bridge.sv
// Bridges the core's single-word data port onto single-beat AXI3 reads/writes.
// Optional kseg0/kseg1 address folding is enabled with `define DBUS_ADDR_MAP_EN.
module dbus_axi_bridge #(
  parameter int unsigned AXI_ID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        d_stall,
  input  logic        longest_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  arlen,
  output logic [3:0]  awlen,
  output logic [1:0]  arburst,
  output logic [1:0]  awburst,
  output logic [1:0]  arlock,
  output logic [1:0]  awlock,
  output logic [3:0]  arcache,
  output logic [3:0]  awcache,
  output logic [2:0]  arprot,
  output logic [2:0]  awprot,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid,
  input  logic [1:0]  bresp,
  input  logic [3:0]  bid,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AWW  = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Handshakes: a channel transfers on a rising edge where its valid and ready
  // are both high; valids from this block stay up until that edge.
  state_t      state_q;
  logic [31:0] addr_q, wdata_q, mem_rdata_q;
  logic [3:0]  sel_q;
  logic [2:0]  awsize_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        abandon_q, aw_ok_q, w_ok_q;

  function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef DBUS_ADDR_MAP_EN
    map_addr = (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
    map_addr = a;
`endif
  endfunction

  function automatic logic [2:0] size_of_sel(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of_sel = 3'd0;
      4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100: size_of_sel = 3'd1;
      default: size_of_sel = 3'd2;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      awsize_q    <= 3'd2;
      mem_rdata_q <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      abandon_q   <= 1'b0;
      aw_ok_q     <= 1'b0;
      w_ok_q      <= 1'b0;
    end else begin
      // A flushed request still drains on AXI but must not hand data to the core.
      if ((state_q inside {S_AR, S_R, S_AWW, S_B}) && !mem_en)
        abandon_q <= 1'b1;
      case (state_q)
        S_IDLE: if (mem_en) begin
          addr_q    <= map_addr(mem_addr);
          wdata_q   <= mem_wdata;
          sel_q     <= mem_sel;
          awsize_q  <= size_of_sel(mem_sel);
          abandon_q <= 1'b0;
          if (mem_sel == 4'b0000) begin
            state_q   <= S_AR;
            arvalid_q <= 1'b1;
          end else begin
            state_q   <= S_AWW;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
          end
        end
        S_AR: if (arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= S_R;
        end
        S_R: if (rvalid) begin
          mem_rdata_q <= rdata;
          rready_q    <= 1'b0;
          state_q     <= (abandon_q || !mem_en) ? S_IDLE : S_DONE;
        end
        S_AWW: begin
          if (awvalid_q && awready) begin
            awvalid_q <= 1'b0;
            aw_ok_q   <= 1'b1;
          end
          if (wvalid_q && wready) begin
            wvalid_q <= 1'b0;
            w_ok_q   <= 1'b1;
          end
          if ((aw_ok_q || awready) && (w_ok_q || wready)) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= S_B;
          end
        end
        S_B: if (bvalid) begin
          bready_q <= 1'b0;
          state_q  <= (abandon_q || !mem_en) ? S_IDLE : S_DONE;
        end
        S_DONE: if (!longest_stall) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign d_stall   = mem_en && (state_q != S_DONE);
  assign mem_rdata = mem_rdata_q;
  assign dbg_state = state_q;

  assign arid    = AXI_ID[3:0];
  assign awid    = AXI_ID[3:0];
  assign wid     = AXI_ID[3:0];
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = 3'd2;
  assign awsize  = awsize_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign wdata   = wdata_q;
  assign wstrb   = sel_q;
  assign wlast   = 1'b1;

  assign arlen   = 4'd0;
  assign awlen   = 4'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'd0;
  assign awlock  = 2'd0;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;

  logic unused_inputs;
  assign unused_inputs = ^{rresp, rlast, rid, bresp, bid};

endmodule

// File: tb/tb_dbus_axi_bridge.sv
// Directed bench for dbus_axi_bridge: reactive AXI slave, handshake monitor
// with expected-address/beat queues, and a linear sequence of core requests.
module tb_dbus_axi_bridge;

  logic        clk = 1'b0;
  logic        rst, mem_en, longest_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;
  logic        d_stall;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb, arlen, awlen, arcache, awcache;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic [2:0]  arprot, awprot;
  logic [2:0]  dbg_state;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_AR = 3'd1, ST_R = 3'd2,
                         ST_AWW = 3'd3, ST_DONE = 3'd5;

  int n_vec = 0, n_err = 0;
  int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
  logic [31:0] exp_q[$];
  logic [39:0] exp_wq[$];
  int aw_wait = 0, w_wait = 0, r_wait = 0;
  int aw_cnt = 0, w_cnt = 0, r_cnt = 0;
  logic [31:0] slave_rdata = '0;

  logic [3:0]  st_sel[4]   = '{4'b0011, 4'b1111, 4'b0100, 4'b0111};
  logic [31:0] st_data[4]  = '{32'h0000_1234, 32'hCAFE_F00D, 32'h00AB_0000, 32'h0011_2233};
  int          st_aww[4]   = '{0, 0, 1, 0};
  int          st_ww[4]    = '{2, 0, 0, 0};
  logic [2:0]  st_size[4]  = '{3'd1, 3'd2, 3'd0, 3'd2};
  int          st_stall[4] = '{5, 3, 4, 3};
  logic [31:0] map_addrs[4] = '{32'hBFC0_0000, 32'h8000_0004, 32'hC000_0000, 32'h7FFF_FFF0};

  always #5 clk = ~clk;

  dbus_axi_bridge #(.AXI_ID(1)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .d_stall(d_stall), .longest_stall(longest_stall),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .arlen(arlen), .awlen(awlen), .arburst(arburst), .awburst(awburst),
    .arlock(arlock), .awlock(awlock), .arcache(arcache), .awcache(awcache),
    .arprot(arprot), .awprot(awprot),
    .rresp(2'b00), .rlast(1'b1), .rid(4'd1), .bresp(2'b00), .bid(4'd1),
    .dbg_state(dbg_state)
  );

  function automatic logic [31:0] map_model(input logic [31:0] a);
`ifdef DBUS_ADDR_MAP_EN
    return (a[31:30] == 2'b10) ? (a & 32'h1FFF_FFFF) : a;
`else
    return a;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int stalls);
    mem_en = 1'b1; mem_addr = a; mem_wdata = d; mem_sel = s;
    #1;
    stalls = 0;
    while (d_stall && stalls < 50) begin
      stalls++;
      step();
    end
    if (stalls >= 50) begin
      n_err++;
      $error("FAIL access_timeout: observed %0d stall cycles expected completion", stalls);
    end
  endtask

  // Zero-wait-capable slave; reacts #1 after each edge to registered DUT outputs.
  initial begin
    arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        aw_cnt = 0; w_cnt = 0; r_cnt = 0;
      end else begin
        arready = arvalid;
        rdata   = slave_rdata;
        if (rready) begin rvalid = (r_cnt >= r_wait); r_cnt++; end
        else begin rvalid = 0; r_cnt = 0; end
        if (awvalid) begin awready = (aw_cnt >= aw_wait); aw_cnt++; end
        else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_wait); w_cnt++; end
        else begin wready = 0; w_cnt = 0; end
        bvalid = bready;
      end
    end
  end

  // Handshake monitor: pops the scoreboard on every AXI transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (arvalid && arready) begin
        n_ar++;
        if (exp_q.size() > 0) chk("araddr", araddr, exp_q.pop_front());
        else begin n_err++; $error("FAIL ar_unexpected: observed %0h expected none", araddr); end
        chk("arsize", arsize, 3'd2);
        chk("arid", arid, 4'd1);
      end
      if (awvalid && awready) begin
        n_aw++;
        if (exp_q.size() > 0) chk("awaddr", awaddr, exp_q.pop_front());
        else begin n_err++; $error("FAIL aw_unexpected: observed %0h expected none", awaddr); end
      end
      if (wvalid && wready) begin
        n_w++;
        if (exp_wq.size() > 0) chk("wbeat", {awsize, wstrb, wdata, wlast}, exp_wq.pop_front());
        else begin n_err++; $error("FAIL w_unexpected: observed %0h expected none", wdata); end
      end
      if (bvalid && bready) n_b++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int st, ar0, b0;
    logic [31:0] held;
    rst = 1; mem_en = 0; mem_addr = '0; mem_wdata = '0; mem_sel = '0; longest_stall = 0;
    repeat (3) step();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_dstall", d_stall, 1'b0);
    chk("const_burst", {arburst, awburst, arlen, awlen}, 12'b0101_0000_0000);
    rst = 0;
    step();

    // Plain load, zero-wait slave.
    slave_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(map_model(32'h1FC0_0010));
    ar0 = n_ar;
    access(32'h1FC0_0010, 32'h0, 4'b0000, st);
    chk("ld_stall", st, 3);
    chk("ld_state", dbg_state, ST_DONE);
    chk("ld_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("ld_ar_count", n_ar - ar0, 1);
    mem_en = 0;
    step();
    chk("ld_idle", dbg_state, ST_IDLE);

    // Stores with various strobes and ready skews.
    for (int i = 0; i < 4; i++) begin
      aw_wait = st_aww[i]; w_wait = st_ww[i];
      exp_q.push_back(32'h0000_0100 + 32'(i * 4));
      exp_wq.push_back({st_size[i], st_sel[i], st_data[i], 1'b1});
      b0 = n_b;
      access(32'h0000_0100 + 32'(i * 4), st_data[i], st_sel[i], st);
      chk("st_stall", st, st_stall[i]);
      chk("st_state", dbg_state, ST_DONE);
      chk("st_b_count", n_b - b0, 1);
      chk("st_valids_low", {awvalid, wvalid, bready}, 3'b0);
      mem_en = 0;
      step();
    end
    aw_wait = 0; w_wait = 0;

    // Load completes while the pipeline stays stalled.
    longest_stall = 1;
    slave_rdata = 32'h1357_9BDF;
    exp_q.push_back(map_model(32'h0000_2000));
    ar0 = n_ar;
    access(32'h0000_2000, 32'h0, 4'b0000, st);
    chk("hold_stall", st, 3);
    held = mem_rdata;
    chk("hold_rdata0", held, 32'h1357_9BDF);
    slave_rdata = 32'hFFFF_0000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_state", dbg_state, ST_DONE);
      chk("hold_rdata", mem_rdata, 32'h1357_9BDF);
      chk("hold_no_ar", arvalid, 1'b0);
      chk("hold_dstall", d_stall, 1'b0);
    end
    longest_stall = 0; mem_en = 0;
    step();
    chk("hold_release", dbg_state, ST_IDLE);
    chk("hold_ar_count", n_ar - ar0, 1);

    // Flush during R, new load right behind it.
    r_wait = 1;
    slave_rdata = 32'h0A0A_0A0A;
    exp_q.push_back(map_model(32'h0000_0300));
    exp_q.push_back(map_model(32'h0000_0304));
    ar0 = n_ar;
    mem_en = 1; mem_addr = 32'h0000_0300; mem_sel = 4'b0000;
    step();
    chk("ab_ar", dbg_state, ST_AR);
    step();
    chk("ab_r", dbg_state, ST_R);
    mem_en = 0;
    step();
    chk("ab_r_wait", dbg_state, ST_R);
    mem_en = 1; mem_addr = 32'h0000_0304; r_wait = 0; slave_rdata = 32'h0B0B_0B0B;
    #1;
    chk("ab_dstall_new", d_stall, 1'b1);
    step();
    chk("ab_to_idle", dbg_state, ST_IDLE);
    st = 0;
    while (d_stall && st < 50) begin st++; step(); end
    chk("ab_second_stall", st, 3);
    chk("ab_second_rdata", mem_rdata, 32'h0B0B_0B0B);
    chk("ab_second_done", dbg_state, ST_DONE);
    chk("ab_ar_count", n_ar - ar0, 2);
    mem_en = 0;
    step();

    // Reset while the write channels are stalled.
    aw_wait = 100; w_wait = 100;
    mem_en = 1; mem_addr = 32'h0000_0400; mem_wdata = 32'h55; mem_sel = 4'b1111;
    step();
    step();
    chk("rst_aww_state", dbg_state, ST_AWW);
    chk("rst_aww_valids", {awvalid, wvalid}, 2'b11);
    rst = 1; mem_en = 0;
    step();
    chk("rst_mid_state", dbg_state, ST_IDLE);
    chk("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    chk("rst_mid_rdata", mem_rdata, 32'h0);
    rst = 0; aw_wait = 0; w_wait = 0;
    step();

    // Address map boundaries.
    for (int i = 0; i < 4; i++) begin
      slave_rdata = 32'h7700_0000 + 32'(i);
      exp_q.push_back(map_model(map_addrs[i]));
      access(map_addrs[i], 32'h0, 4'b0000, st);
      chk("map_stall", st, 3);
      chk("map_rdata", mem_rdata, 32'h7700_0000 + 32'(i));
      mem_en = 0;
      step();
    end

    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_wq_drained", exp_wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
